// File: rtl/rect_fill_writer.sv
// rect_fill_writer: rasterises filled-rectangle commands into a stream of
// one-pixel-per-clock writes into a linear H_RES x V_RES pixel store.
// Optional feature macro: RECT_CLIP_EN. When defined, rectangles are clipped
// to the screen. When undefined, out-of-screen rectangles are rejected with ERR.
module rect_fill_writer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        WRITE_CLK,
    input  logic        RST_N,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [9:0]  CMD_X,
    input  logic [8:0]  CMD_Y,
    input  logic [9:0]  CMD_W,
    input  logic [8:0]  CMD_H,
    input  logic [23:0] CMD_COLOR,
    output logic [18:0] WRITE_ADDR,
    output logic [23:0] WRITE_DATA,
    output logic        WRITE_EN,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_FILL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [10:0] LP_H_END  = 11'(H_RES);
    localparam logic [10:0] LP_V_END  = 11'(V_RES);
    localparam logic [18:0] LP_STRIDE = 19'(H_RES);

    state_t      r_state;
    state_t      w_state_next;

    // Captured command; stable for the whole command.
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic [9:0]  r_w;
    logic [8:0]  r_h;
    logic [23:0] r_color;

    // Raster walk state.
    logic [10:0] r_x_end;
    logic [10:0] r_y_end;
    logic [9:0]  r_col;
    logic [8:0]  r_row;
    logic [18:0] r_row_base;

    // Registered outputs.
    logic [18:0] r_write_addr;
    logic [23:0] r_write_data;
    logic        r_write_en;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_handshake;
    logic [10:0] w_x_sum;
    logic [10:0] w_y_sum;
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic        w_reject;
    logic        w_empty;
    logic [18:0] w_row_base;
    logic        w_last_col;
    logic        w_last_row;

    assign w_handshake = CMD_VALID && (r_state == S_IDLE);

    // Bounds are evaluated at 11 bits so X+W and Y+H can never wrap.
    assign w_x_sum = {1'b0, r_x} + {1'b0, r_w};
    assign w_y_sum = {2'b0, r_y} + {2'b0, r_h};

`ifdef RECT_CLIP_EN
    assign w_x_end  = (w_x_sum > LP_H_END) ? LP_H_END : w_x_sum;
    assign w_y_end  = (w_y_sum > LP_V_END) ? LP_V_END : w_y_sum;
    assign w_reject = 1'b0;
`else
    assign w_x_end  = w_x_sum;
    assign w_y_end  = w_y_sum;
    assign w_reject = (w_x_sum > LP_H_END) || (w_y_sum > LP_V_END);
`endif

    // A clipped origin beyond the screen leaves end <= start, hence empty.
    assign w_empty = w_reject || (w_x_end <= {1'b0, r_x}) || (w_y_end <= {2'b0, r_y});

    // Row base Y*640 as two shifts for the default stride; generic product otherwise.
    assign w_row_base = (H_RES == 640)
                      ? (({10'b0, r_y} << 9) + ({10'b0, r_y} << 7))
                      : ({10'b0, r_y} * LP_STRIDE);

    assign w_last_col = (({1'b0, r_col} + 11'd1) == r_x_end);
    assign w_last_row = (({2'b0, r_row} + 11'd1) == r_y_end);

    // State register.
    always_ff @(posedge WRITE_CLK or negedge RST_N) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block ordering.
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assigned first so no path leaves w_state_next unassigned
        // (which would infer a latch).
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_handshake) w_state_next = S_SETUP;
            S_SETUP: w_state_next = w_empty ? S_DONE : S_FILL;
            S_FILL:  if (w_last_col && w_last_row) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Command capture, raster walk and registered outputs.
    always_ff @(posedge WRITE_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_x          <= '0;
            r_y          <= '0;
            r_w          <= '0;
            r_h          <= '0;
            r_color      <= '0;
            r_x_end      <= '0;
            r_y_end      <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_row_base   <= '0;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_write_en   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_x     <= CMD_X;
                r_y     <= CMD_Y;
                r_w     <= CMD_W;
                r_h     <= CMD_H;
                r_color <= CMD_COLOR;
            end

            if (r_state == S_SETUP) begin
                // Load the walk and present the first pixel on the same edge.
                r_x_end    <= w_x_end;
                r_y_end    <= w_y_end;
                r_col      <= r_x;
                r_row      <= r_y;
                r_row_base <= w_row_base;
                if (!w_empty) begin
                    r_write_addr <= w_row_base + {9'b0, r_x};
                    r_write_data <= r_color;
                end
            end else if (r_state == S_FILL) begin
                if (!w_last_col) begin
                    r_col        <= r_col + 10'd1;
                    r_write_addr <= r_write_addr + 19'd1;
                end else begin
                    r_col        <= r_x;
                    r_row        <= r_row + 9'd1;
                    r_row_base   <= r_row_base + LP_STRIDE;
                    r_write_addr <= r_row_base + LP_STRIDE + {9'b0, r_x};
                end
            end

            // Outputs decoded from the next state so they line up with it.
            r_write_en <= (w_state_next == S_FILL);
            r_busy     <= (w_state_next != S_IDLE);
            r_done     <= (w_state_next == S_DONE);
            r_err      <= (r_state == S_SETUP) && w_reject;
        end
    end

    assign CMD_READY  = (r_state == S_IDLE);
    assign WRITE_ADDR = r_write_addr;
    assign WRITE_DATA = r_write_data;
    assign WRITE_EN   = r_write_en;
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign ERR        = r_err;

endmodule

// File: tb/tb_rect_fill_writer.sv
// Bench for rect_fill_writer: directed cases plus random rectangles checked
// against a loop-based raster model. Honours RECT_CLIP_EN like the design.
module tb_rect_fill_writer;

    localparam int H_RES = 640;
    localparam int V_RES = 480;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x = '0;
    logic [8:0]  cmd_y = '0;
    logic [9:0]  cmd_w = '0;
    logic [8:0]  cmd_h = '0;
    logic [23:0] cmd_color = '0;
    logic [18:0] write_addr;
    logic [23:0] write_data;
    logic        write_en;
    logic        busy;
    logic        done;
    logic        err;

    rect_fill_writer #(.H_RES(H_RES), .V_RES(V_RES)) dut (
        .WRITE_CLK (clk),
        .RST_N     (rst_n),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD_X     (cmd_x),
        .CMD_Y     (cmd_y),
        .CMD_W     (cmd_w),
        .CMD_H     (cmd_h),
        .CMD_COLOR (cmd_color),
        .WRITE_ADDR(write_addr),
        .WRITE_DATA(write_data),
        .WRITE_EN  (write_en),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [18:0] addr;
        logic [23:0] data;
        int unsigned t;
    } wr_t;

    wr_t         wr_q[$];
    int unsigned done_q[$];
    logic        done_err_q[$];
    logic        excl_viol = 1'b0;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (write_en) wr_q.push_back('{write_addr, write_data, cyc});
        if (done) begin
            done_q.push_back(cyc);
            done_err_q.push_back(err);
        end
        if (cmd_ready && busy) excl_viol = 1'b1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference raster: every (col,row) inside the bounds, row-major.
    int exp_q[$];
    bit exp_err;

    function automatic void model(input int x, input int y, input int w, input int h);
        int xe;
        int ye;
        xe = x + w;
        ye = y + h;
        exp_q.delete();
        exp_err = 1'b0;
`ifdef RECT_CLIP_EN
        if (xe > H_RES) xe = H_RES;
        if (ye > V_RES) ye = V_RES;
`else
        if (xe > H_RES || ye > V_RES) begin
            exp_err = 1'b1;
            return;
        end
`endif
        for (int r = y; r < ye; r++)
            for (int c = x; c < xe; c++)
                exp_q.push_back(r * H_RES + c);
    endfunction

    // Present one command; returns the sample index of the handshake cycle.
    task automatic issue(input int x, input int y, input int w, input int h,
                         input logic [23:0] color, output int unsigned hs);
        int k = 0;
        while (!cmd_ready && k < 400) begin
            tick();
            k++;
        end
        if (k >= 400) check("ready_wait", {63'b0, cmd_ready}, 64'd1);
        wr_q.delete();
        done_q.delete();
        done_err_q.delete();
        cmd_x     = 10'(x);
        cmd_y     = 9'(y);
        cmd_w     = 10'(w);
        cmd_h     = 9'(h);
        cmd_color = color;
        cmd_valid = 1'b1;
        hs = cyc;
        tick();
        cmd_valid = 1'b0;
        // Scramble the bus: it must not be sampled while busy.
        cmd_x     = 10'($urandom);
        cmd_y     = 9'($urandom);
        cmd_w     = 10'($urandom);
        cmd_h     = 9'($urandom);
        cmd_color = 24'($urandom);
    endtask

    // Wait for DONE and compare writes, timing and flags against the model.
    task automatic verify(input string tag, input int unsigned hs, input logic [23:0] color);
        int k = 0;
        int n;
        n = exp_q.size();
        while (done_q.size() == 0 && k < n + 20) begin
            tick();
            k++;
        end
        check({tag, " write_count"}, wr_q.size(), n);
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            check($sformatf("%s addr%0d", tag, i), wr_q[i].addr, exp_q[i]);
            check($sformatf("%s data%0d", tag, i), wr_q[i].data, color);
            check($sformatf("%s wtime%0d", tag, i), wr_q[i].t, hs + 2 + i);
        end
        check({tag, " done_count"}, done_q.size(), 1);
        if (done_q.size() > 0) begin
            check({tag, " done_time"}, done_q[0], hs + 2 + n);
            check({tag, " err"}, {63'b0, done_err_q[0]}, {63'b0, exp_err});
        end
        tick();
        check({tag, " ready_after"}, {63'b0, cmd_ready}, 64'd1);
    endtask

    task automatic run(input string tag, input int x, input int y, input int w,
                       input int h, input logic [23:0] color);
        int unsigned hs;
        model(x, y, w, h);
        issue(x, y, w, h, color, hs);
        verify(tag, hs, color);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " we"},    {63'b0, write_en},   64'd0);
        check({tag, " addr"},  {45'b0, write_addr}, 64'd0);
        check({tag, " data"},  {40'b0, write_data}, 64'd0);
        check({tag, " done"},  {63'b0, done},       64'd0);
        check({tag, " err"},   {63'b0, err},        64'd0);
        check({tag, " busy"},  {63'b0, busy},       64'd0);
        check({tag, " ready"}, {63'b0, cmd_ready},  64'd1);
    endtask

    initial begin
        int unsigned hs;
        int k;
        int rx, ry, rw, rh;

        // Power-on reset.
        #2;
        check_reset_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Small in-bounds rectangle.
        run("basic", 10, 2, 3, 2, 24'hFF00FF);

        // Bottom-right corner overhang: clipped or rejected.
        run("corner", 638, 479, 4, 3, 24'h123456);

        // Zero-width command.
        run("empty_w", 7, 9, 0, 5, 24'hABCDEF);
        run("empty_h", 7, 9, 5, 0, 24'h00FF00);

        // Exact fit against the right and bottom borders.
        run("edge_fit", 636, 477, 4, 3, 24'h0000FF);

        // Back-to-back commands with CMD_VALID held high.
        wr_q.delete();
        done_q.delete();
        done_err_q.delete();
        cmd_x = 10'd0; cmd_y = 9'd0; cmd_w = 10'd2; cmd_h = 9'd1;
        cmd_color = 24'h111111;
        cmd_valid = 1'b1;
        hs = cyc;
        tick();
        cmd_x = 10'd5; cmd_y = 9'd1; cmd_w = 10'd1; cmd_h = 9'd1;
        cmd_color = 24'h222222;
        repeat (5) tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        check("held wcount", wr_q.size(), 3);
        check("held dcount", done_q.size(), 2);
        if (wr_q.size() == 3) begin
            check("held a0", wr_q[0].addr, 0);
            check("held a1", wr_q[1].addr, 1);
            check("held a2", wr_q[2].addr, 645);
            check("held t0", wr_q[0].t, hs + 2);
            check("held t2", wr_q[2].t, hs + 7);
            check("held d0", wr_q[0].data, 24'h111111);
            check("held d2", wr_q[2].data, 24'h222222);
        end
        if (done_q.size() == 2) begin
            check("held done0", done_q[0], hs + 4);
            check("held done1", done_q[1], hs + 8);
        end

        // Full-screen fill interrupted by reset after the 1000th write.
        issue(0, 0, 640, 480, 24'h5A5A5A, hs);
        k = 0;
        while (wr_q.size() < 1000 && k < 1100) begin
            tick();
            k++;
        end
        check("rst fill count", wr_q.size(), 1000);
        if (wr_q.size() >= 1000) check("rst fill a999", wr_q[999].addr, 999);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("rst no_done", done_q.size(), 0);
        check("rst ready", {63'b0, cmd_ready}, 64'd1);
        run("after_rst", 1, 1, 1, 1, 24'hC0FFEE);

        // Random rectangles, biased towards the screen borders.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0:       begin rx = $urandom_range(0, 639);  ry = $urandom_range(0, 479); end
                1:       begin rx = $urandom_range(620, 700); ry = $urandom_range(470, 500); end
                default: begin rx = $urandom_range(0, 1023); ry = $urandom_range(0, 511); end
            endcase
            rw = $urandom_range(0, 24);
            rh = $urandom_range(0, 6);
            run($sformatf("rand%0d", i), rx, ry, rw, rh, 24'($urandom));
        end

        check("ready_busy_exclusive", {63'b0, excl_viol}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
